// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the rv32i register file write port, plus a pending-write scoreboard.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise the load port (1) has fixed priority.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    input  logic        mark_en,
    input  logic [4:0]  mark_reg,
    output logic        wr_en,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data,
    output logic [31:0] busy
);

    logic        grant0;
    logic        grant1;
    logic        handshake;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic [31:0] clear_mask;
    logic [31:0] set_mask;
    logic [31:0] busy_next;

`ifdef WB_ARB_RR_EN
    // last_grant holds the index of the most recently granted port.
    logic last_grant;

    always_comb begin
        grant1 = 1'b0;
        if (req1_valid) begin
            grant1 = !req0_valid || !last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (handshake) begin
            last_grant <= grant1;
        end
    end
`else
    always_comb begin
        grant1 = req1_valid;
    end
`endif

    always_comb begin
        grant0     = req0_valid && !grant1;
        handshake  = grant0 || grant1;
        win_rd     = grant1 ? req1_rd   : req0_rd;
        win_data   = grant1 ? req1_data : req0_data;
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Output stage: writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= 5'd0;
            wr_data <= 32'd0;
        end else if (handshake) begin
            wr_en   <= (win_rd != 5'd0);
            wr_reg  <= win_rd;
            wr_data <= win_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // A mark applied at the same edge as a clear wins, since it belongs to a newer producer.
    always_comb begin
        clear_mask = 32'd0;
        set_mask   = 32'd0;
        if (handshake) begin
            clear_mask = 32'd1 << win_rd;
        end
        if (mark_en && (mark_reg != 5'd0)) begin
            set_mask = 32'd1 << mark_reg;
        end
        busy_next = ((busy & ~clear_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts grants and busy,
// and a queue of expected writes is compared against the registered output stage.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        mark_en;
    logic [4:0]  mark_reg;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [31:0] busy;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .mark_en    (mark_en),
        .mark_reg   (mark_reg),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .busy       (busy)
    );

`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks;
    int          n_fail;
    logic        m_last;
    logic [31:0] m_busy;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        m_last = 1'b1;
        m_busy = 32'd0;
        m_reg  = 5'd0;
        m_data = 32'd0;
    endtask

    // Called at posedge+1; drives inputs, checks grants, advances one clock, checks outputs.
    task automatic applyStimulus(
        input  logic        v0, input logic [4:0] rd0, input logic [31:0] d0,
        input  logic        v1, input logic [4:0] rd1, input logic [31:0] d1,
        input  logic        me, input logic [4:0] mr,
        output logic        g0_obs, output logic g1_obs);
        logic  g0, g1, hs;
        logic [4:0]  rd;
        logic [31:0] d;
        wr_t   exp_w;
        wr_t   got_w;
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
        mark_en    = me; mark_reg = mr;
        #1;
        if (v0 && v1) g1 = RR ? !m_last : 1'b1;
        else          g1 = v1;
        g0 = v0 && !g1;
        hs = g0 || g1;
        rd = g1 ? rd1 : rd0;
        d  = g1 ? d1 : d0;
        g0_obs = req0_ready;
        g1_obs = req1_ready;
        checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        if (hs) begin
            exp_w = '{en: (rd != 5'd0), rd: rd, data: d};
            m_reg = rd; m_data = d;
            if (RR) m_last = g1;
            m_busy[rd] = 1'b0;
        end else begin
            exp_w = '{en: 1'b0, rd: m_reg, data: m_data};
        end
        if (me && mr != 5'd0) m_busy[mr] = 1'b1;
        m_busy[0] = 1'b0;
        exp_q.push_back(exp_w);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("queue_empty", 32'd0, 32'd1);
        end else begin
            exp_w = exp_q.pop_front();
            got_w = '{en: wr_en, rd: wr_reg, data: wr_data};
            checkOutput("wr_en", {31'd0, got_w.en}, {31'd0, exp_w.en});
            checkOutput("wr_reg", {27'd0, got_w.rd}, {27'd0, exp_w.rd});
            checkOutput("wr_data", got_w.data, exp_w.data);
        end
        checkOutput("busy", busy, m_busy);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        mark_en    = 1'b0;
    endtask

    // Called at posedge+1; holds reset for one cycle, then releases away from the edge.
    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("rst_busy", busy, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic g0, g1;
        logic [3:0] exp_g1;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
        mark_en    = 1'b0; mark_reg = 5'd0;
        modelReset();
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] idle after reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, g0, g1);
        end
        checkOutput("idle_wr_reg", {27'd0, wr_reg}, 32'd0);
        checkOutput("idle_wr_data", wr_data, 32'd0);

        $display("[TB] contention, both ports valid");
        exp_g1 = RR ? 4'b1010 : 4'b1111;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h3000_0000 + i, 1'b1, 5'd7, 32'h7000_0000 + i,
                          1'b0, 5'd0, g0, g1);
            checkOutput("contention_g1", {31'd0, g1}, {31'd0, exp_g1[i]});
            checkOutput("contention_g0", {31'd0, g0}, {31'd0, !exp_g1[i]});
        end

        $display("[TB] port 0 alone");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, g0, g1);
        checkOutput("p0_ready", {31'd0, g0}, 32'd1);
        checkOutput("p0_wr_data", wr_data, 32'hDEADBEEF);

        $display("[TB] write to x0 is consumed without a write");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, g0, g1);
        checkOutput("x0_ready", {31'd0, g1}, 32'd1);
        checkOutput("x0_wr_en", {31'd0, wr_en}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, g0, g1);

        $display("[TB] scoreboard");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, g0, g1);
        checkOutput("mark9", {31'd0, busy[9]}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, g0, g1);
        checkOutput("clear9", {31'd0, busy[9]}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, g0, g1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0999, 1'b1, 5'd9, g0, g1);
        checkOutput("mark_beats_clear", {31'd0, busy[9]}, 32'd1);
        applyStimulus(1'b1, 5'd9, 32'h0000_9999, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, g0, g1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, g0, g1);
        checkOutput("mark_x0", busy, 32'd0);

        $display("[TB] back-to-back random traffic");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), g0, g1);
        end

        $display("[TB] asynchronous reset mid-operation");
        @(posedge clk);
        #1;
        doReset();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, g0, g1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, g0, g1);
        applyStimulus(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, g0, g1);
        checkOutput("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
        checkOutput("pre_rst_busy", busy, 32'h0000_0410);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("async_wr_reg", {27'd0, wr_reg}, 32'd0);
        checkOutput("async_wr_data", wr_data, 32'd0);
        checkOutput("async_busy", busy, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, g0, g1);
        checkOutput("post_rst_wr_reg", {27'd0, wr_reg}, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: the execute-stage result (port 0) and the load unit (port 1). It arbitrates using a valid/ready handshake and drives the register file write port from a registered output stage. It also keeps a 32-entry pending-write scoreboard that issue logic uses to stall on in-flight destinations. It sits between the writeback sources and the register file in the rv32i core.

## Interface
Parameters:
- None. Widths are fixed at 5-bit register index and 32-bit data.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  execute writeback request
- req0_ready  output  1  grant to port 0; combinational
- req0_rd  input  5  destination register, port 0
- req0_data  input  32  write data, port 0
- req1_valid  input  1  load writeback request
- req1_ready  output  1  grant to port 1; combinational
- req1_rd  input  5  destination register, port 1
- req1_data  input  32  write data, port 1
- mark_en  input  1  issue logic marks a destination as pending
- mark_reg  input  5  register being marked
- wr_en  output  1  register file write enable; registered
- wr_reg  output  5  register file write index; registered
- wr_data  output  32  register file write data; registered
- busy  output  32  pending-write bitmap; bit i set means xi has an outstanding producer

## Operation
- At most one requester is granted per cycle.
- The output stage never back-pressures, so a lone valid is always granted: reqN_ready = reqN_valid AND (port wins arbitration).
- Arbitration (WB_ARB_RR_EN defined) is round-robin:
  - A last_grant flag is held in a register; its reset value is 1, so port 0 wins the first contention.
  - When both ports are valid, the port not equal to last_grant wins.
  - last_grant updates only on a cycle with a handshake.
- A handshake (valid && ready) at edge N loads the output stage at that edge:
  - wr_reg and wr_data take the winner's rd and data.
  - wr_en is set to (rd != 0).
  - A handshake with rd=0 is consumed normally: ready is asserted and arbitration state advances, but no write is produced.
- No handshake at edge N: wr_en is cleared. wr_reg and wr_data hold their previous values.
- Scoreboard:
  - mark_en with mark_reg != 0 sets busy[mark_reg].
  - A handshake clears busy[rd].
  - If mark and clear hit the same register at the same edge, mark wins (busy stays 1), because a newer producer has been issued.
  - busy[0] is constant 0; marks to x0 are ignored.
- Both requesters targeting the same rd: each is serviced in arbitration order. The last one written wins in the register file.

## Timing
- Request-to-write latency is 1 cycle. A handshake at edge N puts wr_en, wr_reg and wr_data on the output during cycle N+1, and the register file commits at edge N+1.
- busy updates at the handshake edge N. It therefore clears one cycle before the data is in the register file; issue logic must forward from wr_data or wait one more cycle.
- Back-to-back handshakes every cycle are supported; wr_en stays high continuously.
- Values at reset:
  - wr_en = 0, wr_reg = 0, wr_data = 0
  - busy = 0
  - last_grant = 1
  - req0_ready and req1_ready follow their valids combinationally
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously).
  - A write pending in the output stage is dropped.
  - Requesters must re-present their requests after reset.
- Requesters must hold valid, rd and data stable until ready. The block does not check this.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration as described above.
- WB_ARB_RR_EN undefined:
  - Fixed priority, port 1 (load) always beats port 0.
  - The last_grant register is not built.
  - Port 0 may starve while port 1 is continuously valid.
- Scoreboard and output-stage behaviour are identical in both builds.

## Test plan
- Reset release, no requests: wr_en=0, wr_reg=0, wr_data=0, busy=0 for 5 cycles; both readies are 0.
- Port 0 only, rd=5, data=0xDEADBEEF:
  - req0_ready=1 in the same cycle.
  - Next cycle: wr_en=1, wr_reg=5, wr_data=0xDEADBEEF.
- Both valid for 4 consecutive cycles, rd=3 and rd=7:
  - RR build grants 0,1,0,1.
  - Fixed build grants 1,1,1,1 with req0_ready=0 throughout.
- Handshake with rd=0, data=0xFFFFFFFF: ready=1; next cycle wr_en=0.
- Scoreboard:
  - mark_en with mark_reg=9 → busy[9]=1.
  - A later port-1 handshake with rd=9 → busy[9]=0 after that edge.
  - A simultaneous mark of 9 and handshake with rd=9 → busy[9] stays 1.
  - mark_reg=0 leaves busy=0.
- rst_n pulsed low mid-cycle while wr_en=1 and busy=0x00000410: outputs and busy go to 0 immediately, before the next clock edge.
